// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  // Operation encoding used by the control unit when decoding MULT/DIV/DIVM.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit owning HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_t       state_q, state_d;
  logic             op_q, op_d;
  // acc: Booth upper accumulator (sign-extended) or divide partial remainder
  logic [WIDTH:0]   acc_q, acc_d;
  // work: Booth multiplier/lower product or dividend/quotient shift register
  logic [WIDTH-1:0] work_q, work_d;
  logic             qm1_q, qm1_d;
  // opb: multiplicand, or divisor magnitude
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic             add_sub;
  logic [2*WIDTH+1:0] booth_res;
  logic [WIDTH+1:0] div_res;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // One Booth step: optional add/sub of the multiplicand, then arithmetic shift of {acc,work,qm1}.
  function automatic logic [2*WIDTH+1:0] booth_step(input logic [WIDTH:0]   acc,
                                                    input logic [WIDTH-1:0] work,
                                                    input logic             qm1,
                                                    input logic [WIDTH:0]   sum);
    logic [WIDTH:0] p;
    p = (work[0] ^ qm1) ? sum : acc;
    return {p[WIDTH], p, work};
  endfunction

  // One restoring-divide step: keep the trial difference when non-negative, emit quotient bit.
  function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0] shifted,
                                                input logic [WIDTH:0] sum);
    logic ok;
    ok = ~sum[WIDTH];
    return {(ok ? sum : shifted), ok};
  endfunction

  // Shared WIDTH+1-bit adder/subtractor operand selection for both operations.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (state_q == MULT) begin
      add_x   = acc_q;
      add_y   = {opb_q[WIDTH-1], opb_q};
      add_sub = work_q[0] & ~qm1_q;
    end else begin
      add_x   = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
      add_y   = {1'b0, opb_q};
      add_sub = 1'b1;
    end
  end

  assign add_sum = add_x + (add_sub ? ~add_y : add_y) + (WIDTH+1)'(add_sub);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    work_d    = work_q;
    qm1_d     = qm1_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    booth_res = '0;
    div_res   = '0;

    case (state_q)
      IDLE: begin
        if (start_mult || start_div) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          cnt_d  = '0;
          acc_d  = '0;
          qm1_d  = 1'b0;
          if (start_mult) begin
            state_d   = MULT;
            op_d      = OP_MULT;
            work_d    = a;
            opb_d     = b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            state_d   = DIV;
            op_d      = OP_DIV;
            work_d    = magnitude(a);
            opb_d     = magnitude(b);
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
          end
        end
      end

      MULT: begin
        booth_res = booth_step(acc_q, work_q, qm1_q, add_sum);
        acc_d     = booth_res[2*WIDTH+1:WIDTH+1];
        work_d    = booth_res[WIDTH:1];
        qm1_d     = booth_res[0];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
        end
      end

      DIV: begin
        if (opb_q == '0) begin
          // Divide by zero: flag it and return without touching HI/LO.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else begin
          div_res = div_step(add_x, add_sum);
          acc_d   = div_res[WIDTH+1:1];
          work_d  = {work_q[WIDTH-2:0], div_res[0]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q == OP_MULT) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = work_q;
        end else begin
          lo_d = negate_if(neg_quo_q, work_q);
          hi_d = negate_if(neg_rem_q, acc_q[WIDTH-1:0]);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      acc_q     <= '0;
      work_q    <= '0;
      qm1_q     <= 1'b0;
      opb_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      qm1_q     <= qm1_d;
      opb_q     <= opb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops vs. arithmetic model, corner sequences.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Reference state of HI/LO/div_zero as the architecture defines them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  typedef struct {
    bit          is_div;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          exp_dz;
  } vec_t;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result of an operation, from plain signed 64-bit arithmetic.
  task automatic model(input bit is_div, input logic [31:0] va, input logic [31:0] vb,
                       output logic [31:0] eh, output logic [31:0] el, output bit edz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    eh = m_hi;
    el = m_lo;
    edz = 1'b0;
    if (!is_div) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (vb == 32'd0) begin
      edz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endtask

  // Issue one operation, wait for done (bounded), then compare results, latency and pulse shape.
  task automatic do_op(input bit sm, input bit sd, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eh, input logic [31:0] el, input bit edz,
                       input string tag);
    int n;
    int elat;
    elat = edz ? 1 : 33;
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a = va;
    b = vb;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 10 && !done) chk({tag, " hi_held_mid_op"}, {hi, lo}, {m_hi, m_lo});
    end
    chk({tag, " latency"}, 64'(n), 64'(elat));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'(0));
    m_hi = eh;
    m_lo = el;
    m_dz = edz;
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] eh, el;
    bit edz;
    int n, dones;

    vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3] = '{1'b1, 32'd5,        32'd0,        32'd2,        32'd14,       1'b1};
    vecs[4] = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{1'b0, 32'd0,        32'd12345,    32'h00000000, 32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[9] = '{1'b1, 32'hDEADBEEF, 32'd0,        32'h00000000, 32'h00000001, 1'b1};

    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset div_zero", 64'(div_zero), 64'(0));
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].va, vecs[i].vb,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, $sformatf("vec%0d", i));
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      bit is_div;
      logic [31:0] ra, rb;
      is_div = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(is_div, ra, rb, eh, el, edz);
      do_op(!is_div, is_div, ra, rb, eh, el, edz, $sformatf("rnd%0d", i));
    end

    // Both starts together: multiply wins; a start_div mid-operation is ignored.
    @(negedge clk);
    start_mult = 1'b1;
    start_div  = 1'b1;
    a = 32'd6;
    b = 32'd4;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    n = 0;
    dones = 0;
    eh = 32'hX;
    el = 32'hX;
    while (n < 45) begin
      if (n == 10) begin
        start_div = 1'b1;
        a = 32'd100;
        b = 32'd7;
      end
      @(negedge clk);
      n++;
      start_div = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("arb latency", 64'(n), 64'(33));
          eh = hi;
          el = lo;
        end
      end
    end
    chk("arb done_count", 64'(dones), 64'(1));
    chk("arb hi", 64'(eh), 64'(0));
    chk("arb lo", 64'(el), 64'(24));
    chk("arb busy_idle", 64'(busy), 64'(0));
    m_hi = 32'd0;
    m_lo = 32'd24;

    // Reset in the middle of a multiply aborts with no done pulse.
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'd123;
    b = 32'd456;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid busy", 64'(busy), 64'(0));
    chk("rst_mid hi", 64'(hi), 64'(0));
    chk("rst_mid lo", 64'(lo), 64'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid no_done", 64'(dones), 64'(0));
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;

    // Unit is usable again after the abort.
    model(1'b0, 32'hFFFF0000, 32'd3, eh, el, edz);
    do_op(1'b1, 1'b0, 32'hFFFF0000, 32'd3, eh, el, edz, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
